// File: rtl/port_bank_pkg.sv
// -----------------------------------------------------------------------------
// port_bank_pkg
// Shared definitions for the CPU I/O port bank: default bus width, the
// classification of a decoded port access, and helpers that place the
// fixed-function ports (SW, BTNEV, DSEL) directly after the NUM_OUT output
// registers in the address map.
// -----------------------------------------------------------------------------
package port_bank_pkg;

    localparam int WORD_SIZE_DEFAULT = 16;
    localparam int SW_WIDTH          = 8;
    localparam int SSD_WIDTH         = 16;

    // What kind of port a bus address lands on after decode.
    typedef enum logic [2:0] {
        KIND_NONE,
        KIND_OUT,
        KIND_SW,
        KIND_BTNEV,
        KIND_DSEL
    } port_kind_e;

    // Offsets of the fixed ports, relative to the size of the output register file.
    function automatic int port_ofs_sw(input int num_out);
        return num_out;
    endfunction

    function automatic int port_ofs_btnev(input int num_out);
        return num_out + 1;
    endfunction

    function automatic int port_ofs_dsel(input int num_out);
        return num_out + 2;
    endfunction

endpackage

// File: rtl/port_bank_debounce.sv
// -----------------------------------------------------------------------------
// port_debounce
// One button channel: 2-flop synchroniser, stability counter, accepted level
// and a one-cycle pulse when the accepted level goes 0 -> 1.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   btn_raw  in  raw, bouncy, asynchronous button level
//   rise     out one-cycle pulse on a 0 -> 1 change of the accepted level
// -----------------------------------------------------------------------------
module port_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain before anything looks at it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // The counter measures how long the synchronised input has disagreed
    // with the accepted level; any agreement (a bounce back) restarts it.
    // Once the disagreement has lasted long enough, the new level is accepted,
    // which makes the two agree again and parks the counter at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                rise  <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_bank.sv
// -----------------------------------------------------------------------------
// port_bank
// CPU I/O port peripheral. Decodes the cpu port bus and provides NUM_OUT
// read/write output registers, a synchronised switch port, a sticky
// debounced button-event port and a display-select register that chooses
// which output register feeds the seven-segment driver.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   portaddr   port address from cpu (full WORD_SIZE compare)
//   portval    write data from cpu
//   portset    single-cycle write strobe
//   portget    single-cycle read strobe
//   portout    registered read data, held until the next read
//   portready  one-cycle pulse for every read strobe, one cycle later
//   sw         raw switches
//   btn        raw buttons
//   show_val   low 16 bits of the selected output register
// -----------------------------------------------------------------------------
module port_bank
    import port_bank_pkg::*;
#(
    parameter int WORD_SIZE       = WORD_SIZE_DEFAULT,
    parameter int NUM_OUT         = 4,
    parameter int NUM_BTN         = 4,
    parameter int BASE_ADDR       = 0,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] portaddr,
    input  logic [WORD_SIZE-1:0] portval,
    input  logic                 portset,
    input  logic                 portget,
    output logic [WORD_SIZE-1:0] portout,
    output logic                 portready,
    input  logic [SW_WIDTH-1:0]  sw,
    input  logic [NUM_BTN-1:0]   btn,
    output logic [SSD_WIDTH-1:0] show_val
);

    localparam int SEL_W = $clog2(NUM_OUT);
    localparam logic [WORD_SIZE-1:0] BASE      = WORD_SIZE'(BASE_ADDR);
    localparam logic [WORD_SIZE-1:0] NUM_OUT_W = WORD_SIZE'(NUM_OUT);
    localparam logic [WORD_SIZE-1:0] OFS_SW    = WORD_SIZE'(port_ofs_sw(NUM_OUT));
    localparam logic [WORD_SIZE-1:0] OFS_BTNEV = WORD_SIZE'(port_ofs_btnev(NUM_OUT));
    localparam logic [WORD_SIZE-1:0] OFS_DSEL  = WORD_SIZE'(port_ofs_dsel(NUM_OUT));

    logic [WORD_SIZE-1:0] out_reg [NUM_OUT];
    logic [SEL_W-1:0]     disp_sel;
    logic [NUM_BTN-1:0]   btn_ev;
    logic [NUM_BTN-1:0]   btn_rise;
    logic [SW_WIDTH-1:0]  sw_sync1;
    logic [SW_WIDTH-1:0]  sw_sync2;

    logic                 borrow;
    logic [WORD_SIZE-1:0] offset;
    port_kind_e           kind;
    logic [SEL_W-1:0]     out_idx;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 ev_clear;

    // The subtraction is done one bit wider so an address below BASE shows up
    // as a borrow instead of wrapping around onto a valid offset.
    always_comb begin
        {borrow, offset} = {1'b0, portaddr} - {1'b0, BASE};
        out_idx = offset[SEL_W-1:0];
        kind    = KIND_NONE;
        if (!borrow) begin
            if (offset < NUM_OUT_W)
                kind = KIND_OUT;
            else if (offset == OFS_SW)
                kind = KIND_SW;
            else if (offset == OFS_BTNEV)
                kind = KIND_BTNEV;
            else if (offset == OFS_DSEL)
                kind = KIND_DSEL;
        end
    end

    // Read mux; unclaimed addresses read as zero.
    always_comb begin
        rd_data = '0;
        case (kind)
            KIND_OUT:   rd_data = out_reg[out_idx];
            KIND_SW:    rd_data = WORD_SIZE'(sw_sync2);
            KIND_BTNEV: rd_data = WORD_SIZE'(btn_ev);
            KIND_DSEL:  rd_data = WORD_SIZE'(disp_sel);
            default:    rd_data = '0;
        endcase
    end

    assign ev_clear = portget && (kind == KIND_BTNEV);

    // Writable state: output registers and the display select. SW and BTNEV
    // are read-only, so writes to them simply fall through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++)
                out_reg[i] <= '0;
            disp_sel <= '0;
        end else if (portset) begin
            if (kind == KIND_OUT)
                out_reg[out_idx] <= portval;
            else if (kind == KIND_DSEL)
                disp_sel <= portval[SEL_W-1:0];
        end
    end

    // Sticky button events. A read clears exactly the bits it returned, but a
    // new rising edge in the same cycle is ORed in afterwards so it survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            btn_ev <= '0;
        else if (ev_clear)
            btn_ev <= btn_rise;
        else
            btn_ev <= btn_ev | btn_rise;
    end

    // Read response: every strobe gets a ready pulse; data is held between reads.
    // Because the mux sees pre-edge state, a same-cycle write is not visible yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            portout   <= '0;
            portready <= 1'b0;
        end else begin
            portready <= portget;
            if (portget)
                portout <= rd_data;
        end
    end

    // Switches are not debounced, only synchronised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_sync1 <= '0;
            sw_sync2 <= '0;
        end else begin
            sw_sync1 <= sw;
            sw_sync2 <= sw_sync1;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        port_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn[g]),
            .rise   (btn_rise[g])
        );
    end

    assign show_val = SSD_WIDTH'(out_reg[disp_sel]);

endmodule
